// File: rtl/iddmm_seq_ctrl.sv
// rtl/iddmm_seq_ctrl.sv - IDDMM PE-array row/word sequencer with write-back tracking and final-subtract handshake
// Issue registers drive the read addresses; one-cycle-later control copies drive PE strobes and a LAT-deep delay line.
module iddmm_seq_ctrl #(
   parameter int N_MAX  = 32,
   parameter int ADDR_W = $clog2(N_MAX),
   parameter int LAT    = 8,
   parameter bit ISSUE2 = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              task_req,
   input  logic [ADDR_W:0]   n_words,
   input  logic              abort,
   output logic              task_ack,
   output logic              task_err,
   output logic              task_done,
   output logic              busy,
   output logic              ctl_carry_clr,
   output logic              ctl_carry_ena,
   output logic              ctl_carry_sel,
   output logic              ctl_c_pre_clr,
   output logic              ctl_c_pre_ena,
   output logic              ctl_q_ena,
   input  logic              carry,
   output logic [ADDR_W:0]   ref_addr_rdx,
   output logic [ADDR_W-1:0] ref_addr_rdy,
   output logic [ADDR_W-1:0] ref_addr_rdm,
   output logic [ADDR_W-1:0] ref_addr_rda,
   output logic              ref_wr_n,
   output logic [ADDR_W-1:0] ref_wr_a_addr,
   output logic              ref_wr_a_ena,
   output logic              ref_an,
   output logic              comp_req,
   input  logic              comp_end
);
   typedef enum logic [2:0] {S_IDLE, S_HEAD, S_SCAN, S_DRAIN, S_FINAL} state_t;

   localparam logic [ADDR_W:0] NMAX_W = (ADDR_W+1)'(N_MAX);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   n_q, n_d, j_q, j_d;
   logic [ADDR_W-1:0] i_q, i_d;
   logic              j00_q, j00_d, jref_q, jref_d;
   logic              ack_q, ack_d, err_q, err_d, done_q, done_d;
   logic              busy_q, busy_d, creq_q, creq_d, an_q, an_d;

   logic [ADDR_W:0]   cj_q;
   logic              cph_q, cclr_q, cena_q, csel_q, cpclr_q;
   logic [LAT-1:0][ADDR_W:0] dl_j_q;
   logic [LAT-1:0]           dl_ph_q;

   logic            ph, act, last_j, last_i, drained, flush;
   logic [ADDR_W:0] tail_j, tail_jm1;

   assign ph      = ISSUE2 ? jref_q : 1'b1;
   assign act     = (state_q == S_HEAD) || (state_q == S_SCAN);
   assign last_j  = (j_q == n_q);
   assign last_i  = ({1'b0, i_q} == (n_q - 1'b1));
   assign drained = (cj_q == '0) && (dl_j_q == '0);
   assign flush   = abort && (state_q != S_IDLE);

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      i_d     = i_q;
      j_d     = j_q;
      j00_d   = j00_q;
      jref_d  = jref_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      done_d  = 1'b0;
      busy_d  = busy_q;
      creq_d  = creq_q;
      an_d    = an_q;
      case (state_q)
         S_IDLE: begin
            if (task_req && !abort) begin
               if ((n_words != '0) && (n_words <= NMAX_W)) begin
                  n_d     = n_words;
                  ack_d   = 1'b1;
                  busy_d  = 1'b1;
                  i_d     = '0;
                  j_d     = '0;
                  j00_d   = 1'b1;
                  jref_d  = 1'b0;
                  state_d = S_HEAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_HEAD: begin
            j_d     = '0;
            j00_d   = 1'b0;
            jref_d  = 1'b0;
            state_d = S_SCAN;
         end
         S_SCAN: begin
            if (last_j && ph) begin
               j_d    = '0;
               jref_d = 1'b0;
               if (last_i) begin
                  i_d     = '0;
                  state_d = S_DRAIN;
               end else begin
                  i_d     = i_q + 1'b1;
                  j00_d   = 1'b1;
                  state_d = S_HEAD;
               end
            end else if (ISSUE2) begin
               jref_d = ~jref_q;
               if (jref_q) j_d = j_q + 1'b1;
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         S_DRAIN: begin
            // carry is final only once every in-flight column has been written back
            if (drained) begin
               an_d    = carry;
               creq_d  = 1'b1;
               state_d = S_FINAL;
            end
         end
         S_FINAL: begin
            if (comp_end) begin
               creq_d  = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         creq_d  = 1'b0;
         done_d  = 1'b0;
         an_d    = an_q;
         i_d     = '0;
         j_d     = '0;
         j00_d   = 1'b0;
         jref_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         j00_q   <= 1'b0;
         jref_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         creq_q  <= 1'b0;
         an_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         i_q     <= i_d;
         j_q     <= j_d;
         j00_q   <= j00_d;
         jref_q  <= jref_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         creq_q  <= creq_d;
         an_q    <= an_d;
      end
   end

   // Control copies are gated by act so idle/drain cycles present all-zero strobes.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cj_q    <= '0;
         cph_q   <= 1'b0;
         cclr_q  <= 1'b0;
         cena_q  <= 1'b0;
         csel_q  <= 1'b0;
         cpclr_q <= 1'b0;
         dl_j_q  <= '0;
         dl_ph_q <= '0;
      end else begin
         cj_q       <= act ? j_q : '0;
         cph_q      <= act && ph;
         cclr_q     <= act && j00_q && (j_q == '0) && (i_q == '0);
         cena_q     <= act && last_j && ph;
         csel_q     <= act && last_j;
         cpclr_q    <= act && j00_q && (j_q == '0);
         dl_j_q[0]  <= cj_q;
         dl_ph_q[0] <= cph_q;
         for (int k = 1; k < LAT; k++) begin
            dl_j_q[k]  <= dl_j_q[k-1];
            dl_ph_q[k] <= dl_ph_q[k-1];
         end
      end
   end

   assign tail_j   = dl_j_q[LAT-1];
   assign tail_jm1 = tail_j - 1'b1;

   assign task_ack      = ack_q;
   assign task_err      = err_q;
   assign task_done     = done_q;
   assign busy          = busy_q;
   assign comp_req      = creq_q;
   assign ref_an        = an_q;
   assign ctl_carry_clr = cclr_q;
   assign ctl_carry_ena = cena_q;
   assign ctl_carry_sel = csel_q;
   assign ctl_c_pre_clr = cpclr_q;
   assign ctl_c_pre_ena = cph_q;
   assign ctl_q_ena     = cpclr_q;
   assign ref_wr_n      = csel_q;
   assign ref_addr_rdx  = j_q;
   assign ref_addr_rdy  = i_q;
   assign ref_addr_rdm  = j_q[ADDR_W-1:0];
   assign ref_addr_rda  = j_q[ADDR_W-1:0];
   assign ref_wr_a_ena  = (tail_j != '0) && dl_ph_q[LAT-1];
   assign ref_wr_a_addr = (tail_j != '0) ? tail_jm1[ADDR_W-1:0] : '0;
endmodule

// File: tb/tb_iddmm_seq_ctrl.sv
// tb/tb_iddmm_seq_ctrl.sv - self-checking bench for iddmm_seq_ctrl
// Unit 0: ISSUE2=0 LAT=4; unit 1: ISSUE2=1 LAT=5; both N_MAX=32.
module tb_iddmm_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       task_req [2];
   logic [5:0] n_words [2];
   logic       abort [2];
   logic       carry [2];
   logic       comp_end [2];
   logic       task_ack [2], task_err [2], task_done [2], busy [2];
   logic       ctl_carry_clr [2], ctl_carry_ena [2], ctl_carry_sel [2];
   logic       ctl_c_pre_clr [2], ctl_c_pre_ena [2], ctl_q_ena [2];
   logic [5:0] ref_addr_rdx [2];
   logic [4:0] ref_addr_rdy [2], ref_addr_rdm [2], ref_addr_rda [2], ref_wr_a_addr [2];
   logic       ref_wr_n [2], ref_wr_a_ena [2], ref_an [2], comp_req [2];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   iddmm_seq_ctrl #(.N_MAX(32), .LAT(4), .ISSUE2(1'b0)) u0 (
      .clk(clk), .rst(rst), .task_req(task_req[0]), .n_words(n_words[0]), .abort(abort[0]),
      .task_ack(task_ack[0]), .task_err(task_err[0]), .task_done(task_done[0]), .busy(busy[0]),
      .ctl_carry_clr(ctl_carry_clr[0]), .ctl_carry_ena(ctl_carry_ena[0]), .ctl_carry_sel(ctl_carry_sel[0]),
      .ctl_c_pre_clr(ctl_c_pre_clr[0]), .ctl_c_pre_ena(ctl_c_pre_ena[0]), .ctl_q_ena(ctl_q_ena[0]),
      .carry(carry[0]), .ref_addr_rdx(ref_addr_rdx[0]), .ref_addr_rdy(ref_addr_rdy[0]),
      .ref_addr_rdm(ref_addr_rdm[0]), .ref_addr_rda(ref_addr_rda[0]), .ref_wr_n(ref_wr_n[0]),
      .ref_wr_a_addr(ref_wr_a_addr[0]), .ref_wr_a_ena(ref_wr_a_ena[0]), .ref_an(ref_an[0]),
      .comp_req(comp_req[0]), .comp_end(comp_end[0]));

   iddmm_seq_ctrl #(.N_MAX(32), .LAT(5), .ISSUE2(1'b1)) u1 (
      .clk(clk), .rst(rst), .task_req(task_req[1]), .n_words(n_words[1]), .abort(abort[1]),
      .task_ack(task_ack[1]), .task_err(task_err[1]), .task_done(task_done[1]), .busy(busy[1]),
      .ctl_carry_clr(ctl_carry_clr[1]), .ctl_carry_ena(ctl_carry_ena[1]), .ctl_carry_sel(ctl_carry_sel[1]),
      .ctl_c_pre_clr(ctl_c_pre_clr[1]), .ctl_c_pre_ena(ctl_c_pre_ena[1]), .ctl_q_ena(ctl_q_ena[1]),
      .carry(carry[1]), .ref_addr_rdx(ref_addr_rdx[1]), .ref_addr_rdy(ref_addr_rdy[1]),
      .ref_addr_rdm(ref_addr_rdm[1]), .ref_addr_rda(ref_addr_rda[1]), .ref_wr_n(ref_wr_n[1]),
      .ref_wr_a_addr(ref_wr_a_addr[1]), .ref_wr_a_ena(ref_wr_a_ena[1]), .ref_an(ref_an[1]),
      .comp_req(comp_req[1]), .comp_end(comp_end[1]));

   // One issue slot of the reference schedule.
   typedef struct { int j; int i; bit ph; bit j00; } iss_t;
   iss_t exp_q[$];

   typedef struct { int u; int n; bit ab; bit e_ack; bit e_err; } req_vec_t;
   req_vec_t tv[7];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
      n_chk++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, expv, $time);
      end
   endtask

   // Row = head slot, then j=0..n (each j twice, phase 0 then 1, in dual-issue mode).
   function automatic void build(input int n, input bit iss);
      iss_t r;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         r.i = i; r.j = 0; r.j00 = 1'b1; r.ph = !iss;
         exp_q.push_back(r);
         r.j00 = 1'b0;
         for (int j = 0; j <= n; j++) begin
            r.j = j;
            if (iss) begin
               r.ph = 1'b0; exp_q.push_back(r);
               r.ph = 1'b1; exp_q.push_back(r);
            end else begin
               r.ph = 1'b1; exp_q.push_back(r);
            end
         end
      end
   endfunction

   function automatic logic [17:0] obs(input int u);
      return {ctl_carry_clr[u], ctl_carry_ena[u], ctl_carry_sel[u], ctl_c_pre_clr[u],
              ctl_c_pre_ena[u], ctl_q_ena[u], ref_wr_n[u], ref_wr_a_ena[u],
              ref_wr_a_ena[u] ? ref_wr_a_addr[u] : 5'd0, comp_req[u], busy[u],
              task_ack[u], task_err[u], task_done[u]};
   endfunction

   function automatic logic [17:0] exp_vec(input int t, input int n, input int lat, input bit creq_e);
      int k, w, len;
      logic cc, ce, cs, pc, pe, we;
      logic [4:0] wa;
      len = exp_q.size(); k = t - 1; w = t - 1 - lat;
      cc = 0; ce = 0; cs = 0; pc = 0; pe = 0; we = 0; wa = '0;
      if (k >= 0 && k < len) begin
         cc = exp_q[k].j00 && (exp_q[k].i == 0);
         cs = (exp_q[k].j == n);
         ce = cs && exp_q[k].ph;
         pc = exp_q[k].j00;
         pe = exp_q[k].ph;
      end
      if (w >= 0 && w < len && exp_q[w].j != 0 && exp_q[w].ph) begin
         we = 1'b1;
         wa = 5'(exp_q[w].j - 1);
      end
      return {cc, ce, cs, pc, pe, pc, cs, we, wa, creq_e, 1'b1, 3'b000};
   endfunction

   task automatic run_task(input int u, input int n, input bit cv, input int edly,
                           output int nwr, output int nclr, output int npclr,
                           output int ncena, output int span);
      int len, lat, tcreq;
      lat = (u == 1) ? 5 : 4;
      build(n, u == 1);
      len = exp_q.size();
      tcreq = len + lat + 2;
      nwr = 0; nclr = 0; npclr = 0; ncena = 0; span = -1;
      carry[u] = cv; n_words[u] = 6'(n); task_req[u] = 1'b1;
      @(negedge clk);
      task_req[u] = 1'b0;
      chk("ack", 32'(task_ack[u]), 1);
      chk("busy_start", 32'(busy[u]), 1);
      for (int t = 0; t <= tcreq; t++) begin
         if (t > 0) @(negedge clk);
         if (t < len) begin
            chk("rdx", 32'(ref_addr_rdx[u]), exp_q[t].j);
            chk("rdy", 32'(ref_addr_rdy[u]), exp_q[t].i);
            chk("rdm", 32'(ref_addr_rdm[u]), exp_q[t].j % 32);
            comp_end[u] = 1'($urandom_range(0, 1));
         end else begin
            comp_end[u] = 1'b0;
         end
         if (t > 0) chk("cycle", 32'(obs(u)), 32'(exp_vec(t, n, lat, t == tcreq)));
         nwr   += int'(ref_wr_a_ena[u]);
         nclr  += int'(ctl_carry_clr[u]);
         npclr += int'(ctl_c_pre_clr[u]);
         ncena += int'(ctl_carry_ena[u]);
         if (ctl_carry_ena[u]) span = t;
      end
      chk("ref_an", 32'(ref_an[u]), 32'(cv));
      n_words[u] = 6'd2;
      task_req[u] = (edly > 0);
      for (int d = 0; d < edly; d++) begin
         @(negedge clk);
         chk("final_hold", 32'({comp_req[u], task_ack[u], task_err[u], task_done[u]}), 32'h8);
      end
      task_req[u] = 1'b0;
      comp_end[u] = 1'b1;
      @(negedge clk);
      comp_end[u] = 1'b0;
      chk("done", 32'({task_done[u], comp_req[u], busy[u], ref_an[u]}), 32'({1'b1, 1'b0, 1'b0, cv}));
      @(negedge clk);
      chk("done_pulse", 32'({task_done[u], busy[u], task_ack[u]}), 0);
   endtask

   int nwr, nclr, npclr, ncena, span;
   bit found;

   initial begin
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         task_req[u] = 0; n_words[u] = 0; abort[u] = 0; carry[u] = 0; comp_end[u] = 0;
      end
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("reset_ctl", 32'({obs(u), ref_wr_a_addr[u], ref_an[u]}), 0);
         chk("reset_addr", 32'({ref_addr_rdx[u], ref_addr_rdy[u], ref_addr_rdm[u], ref_addr_rda[u]}), 0);
      end
      rst = 1'b0;
      @(negedge clk);

      tv[0] = '{0, 0, 0, 0, 1};
      tv[1] = '{0, 33, 0, 0, 1};
      tv[2] = '{1, 0, 0, 0, 1};
      tv[3] = '{1, 63, 0, 0, 1};
      tv[4] = '{0, 3, 1, 0, 0};
      tv[5] = '{0, 32, 0, 1, 0};
      tv[6] = '{1, 1, 1, 0, 0};
      for (int v = 0; v < 7; v++) begin
         n_words[tv[v].u] = 6'(tv[v].n);
         task_req[tv[v].u] = 1'b1;
         abort[tv[v].u] = tv[v].ab;
         @(negedge clk);
         task_req[tv[v].u] = 1'b0;
         abort[tv[v].u] = 1'b0;
         chk($sformatf("req_vec%0d", v), 32'({task_ack[tv[v].u], task_err[tv[v].u], busy[tv[v].u]}),
             32'({tv[v].e_ack, tv[v].e_err, tv[v].e_ack}));
         if (tv[v].e_ack) begin
            abort[tv[v].u] = 1'b1;
            @(negedge clk);
            abort[tv[v].u] = 1'b0;
            chk("req_abort", 32'(busy[tv[v].u]), 0);
         end
         @(negedge clk);
      end

      run_task(0, 4, 1'b0, 2, nwr, nclr, npclr, ncena, span);
      chk("u0_writes", nwr, 16);
      chk("u0_carry_clr", nclr, 1);
      chk("u0_c_pre_clr", npclr, 4);
      chk("u0_issue_span", span, 24);

      run_task(1, 2, 1'b0, 1, nwr, nclr, npclr, ncena, span);
      chk("u1_writes", nwr, 4);
      chk("u1_carry_ena", ncena, 2);
      chk("u1_issue_span", span, 14);

      run_task(0, 3, 1'b1, 7, nwr, nclr, npclr, ncena, span);
      run_task(1, 1, 1'b1, 0, nwr, nclr, npclr, ncena, span);

      // abort part-way through row 1
      n_words[0] = 6'd4; task_req[0] = 1'b1;
      @(negedge clk);
      task_req[0] = 1'b0;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         if (ref_addr_rdy[0] == 5'd1 && ref_addr_rdx[0] == 6'd2) found = 1;
         else @(negedge clk);
      end
      chk("abort_point_reached", 32'(found), 1);
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      chk("abort_busy", 32'({busy[0], comp_req[0]}), 0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("post_abort", 32'({ref_wr_a_ena[0], task_done[0], busy[0], comp_req[0]}), 0);
      end
      run_task(0, 3, 1'b1, 3, nwr, nclr, npclr, ncena, span);
      chk("after_abort_writes", nwr, 9);

      for (int r = 0; r < 6; r++) begin
         int u;
         u = $urandom_range(0, 1);
         run_task(u, $urandom_range(1, 5), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                  nwr, nclr, npclr, ncena, span);
      end

      // synchronous reset during a scan
      n_words[0] = 6'd4; task_req[0] = 1'b1;
      @(negedge clk);
      task_req[0] = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_ctl", 32'({obs(0), ref_wr_a_addr[0], ref_an[0]}), 0);
      chk("rst_mid_addr", 32'({ref_addr_rdx[0], ref_addr_rdy[0], ref_addr_rdm[0], ref_addr_rda[0]}), 0);
      rst = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
